// File: rtl/im_loader.sv
// Runtime program loader: takes a framed byte stream (magic, 16-bit word count,
// big-endian data words, XOR checksum) and writes it into instruction memory,
// holding the fetch unit in reset while the load runs.
module im_loader #(
    parameter int unsigned IM_BYTES = 1024,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned TIMEOUT  = 50000
) (
    input  logic              clk,
    input  logic              rst_ldr,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [8:0]        words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StData,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [15:0]     MaxWords = 16'(IM_BYTES / 4);
    localparam int unsigned     TmoW     = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT);
    localparam logic [7:0]      Magic    = 8'hA5;

    localparam logic [1:0] ErrNone = 2'b00;
    localparam logic [1:0] ErrLen  = 2'b01;
    localparam logic [1:0] ErrCsum = 2'b10;
    localparam logic [1:0] ErrTmo  = 2'b11;

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [8:0]        words_q, words_d;
    logic [1:0]        err_q, err_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;

    logic              xfer;
    logic              timed;
    logic [15:0]       n_rx;
    logic [TmoW-1:0]   tmo_inc;

    assign xfer    = in_valid && in_ready;
    assign timed   = (state_q == StCntHi) || (state_q == StCntLo) ||
                     (state_q == StData)  || (state_q == StCsum);
    assign n_rx    = {cnt_hi_q, in_byte};
    assign tmo_inc = tmo_q + TmoW'(1);

    // Next-state logic: frame parsing, word assembly, checksum and timeout.
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        count_d    = count_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        waddr_d    = waddr_q;
        words_d    = words_q;
        err_d      = err_q;
        tmo_d      = '0;

        case (state_q)
            StIdle: begin
                if (xfer && in_byte == Magic) begin
                    state_d    = StCntHi;
                    err_d      = ErrNone;
                    words_d    = '0;
                    acc_d      = '0;
                    byte_idx_d = '0;
                    waddr_d    = '0;
                end
            end
            StCntHi: begin
                if (xfer) begin
                    cnt_hi_d = in_byte;
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (xfer) begin
                    count_d = n_rx;
                    if (n_rx > MaxWords) begin
                        state_d = StErr;
                        err_d   = ErrLen;
                    end else if (n_rx == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    word_d     = {word_q[23:0], in_byte};
                    acc_d      = acc_q ^ in_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                words_d = words_q + 9'd1;
                waddr_d = waddr_q + ADDR_W'(4);
                if (({7'd0, words_q} + 16'd1) < count_q) begin
                    state_d = StData;
                end else begin
                    state_d = StCsum;
                end
            end
            StCsum: begin
                if (xfer) begin
                    if (in_byte == acc_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        err_d   = ErrCsum;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A stalled stream mid-frame aborts the load; any transfer restarts the count.
        if (timed && !xfer) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TmoLimit) begin
                state_d = StErr;
                err_d   = ErrTmo;
            end
        end
    end

    // Outputs decoded from the current state and registered datapath.
    always_comb begin
        in_ready     = 1'b1;
        busy         = 1'b1;
        im_we        = 1'b0;
        im_waddr     = '0;
        im_wdata     = '0;
        load_done    = 1'b0;
        load_err     = 1'b0;
        err_code     = err_q;
        words_loaded = words_q;

        case (state_q)
            StIdle: busy = 1'b0;
            StWrite: begin
                in_ready = 1'b0;
                im_we    = 1'b1;
                im_waddr = waddr_q;
                im_wdata = word_q;
            end
            StDone: begin
                in_ready  = 1'b0;
                busy      = 1'b0;
                load_done = 1'b1;
            end
            StErr: begin
                in_ready = 1'b0;
                busy     = 1'b0;
                load_err = 1'b1;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset abandons a load without rollback.
    always_ff @(posedge clk) begin
        if (rst_ldr) begin
            state_q    <= StIdle;
            cnt_hi_q   <= '0;
            count_q    <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            acc_q      <= '0;
            waddr_q    <= '0;
            words_q    <= '0;
            err_q      <= ErrNone;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            count_q    <= count_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            waddr_q    <= waddr_d;
            words_q    <= words_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table of frames plus hand sequences for length error,
// timeout and reset mid-load; expected writes go through a scoreboard queue.
module tb_im_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_ldr;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic [1:0]    err_code;
    logic [8:0]    words_loaded;

    always #5 clk = ~clk;

    im_loader #(
        .IM_BYTES(1024),
        .ADDR_W  (AW),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_ldr     (rst_ldr),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .im_we       (im_we),
        .im_waddr    (im_waddr),
        .im_wdata    (im_wdata),
        .busy        (busy),
        .load_done   (load_done),
        .load_err    (load_err),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        int          garbage;
        int          n;
        bit          use_w0;
        logic [31:0] w0;
        int          gapmax;
        logic [7:0]  flip;
        bit          exp_done;
        logic [1:0]  exp_code;
    } vec_t;

    wr_t exp_q[$];
    int  n_cmp    = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  n_done   = 0;
    int  n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (im_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h, expected no write", im_waddr);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(im_waddr), 32'(e.addr));
                check("wr_data", im_wdata, e.data);
                check("wr_ready_low", 32'(in_ready), 32'd0);
            end
        end
        if (load_done === 1'b1) n_done++;
        if (load_err === 1'b1) n_err++;
    end

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        bit took;
        guard    = 0;
        took     = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!took) begin
            took = (in_ready === 1'b1);
            @(negedge clk);
            guard++;
            if (!took && guard > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_stall: byte 0x%0h not accepted, expected acceptance", b);
                summary();
                $fatal(1, "stream stalled");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [7:0]  garb[3];
        logic [7:0]  acc;
        logic [7:0]  b;
        logic [31:0] w;
        logic [15:0] nn;
        int          w_start;
        garb[0] = 8'h00;
        garb[1] = 8'hFF;
        garb[2] = 8'h3C;
        w_start = n_writes;
        nn      = 16'(v.n);
        for (int i = 0; i < v.garbage; i++) begin
            send_byte(garb[i]);
            check($sformatf("v%0d_garbage_busy", id), 32'(busy), 32'd0);
            check($sformatf("v%0d_garbage_we", id), 32'(im_we), 32'd0);
        end
        send_byte(8'hA5);
        check($sformatf("v%0d_magic_busy", id), 32'(busy), 32'd1);
        check($sformatf("v%0d_magic_code", id), 32'(err_code), 32'd0);
        check($sformatf("v%0d_magic_words", id), 32'(words_loaded), 32'd0);
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        acc = 8'h00;
        for (int k = 0; k < v.n; k++) begin
            w = (v.use_w0 && k == 0) ? v.w0 : $urandom;
            for (int j = 0; j < 4; j++) begin
                b   = w[31 - 8 * j -: 8];
                acc = acc ^ b;
                if (j == 3) exp_q.push_back('{addr: AW'(4 * k), data: w});
                idle($urandom_range(0, v.gapmax));
                send_byte(b);
            end
        end
        idle($urandom_range(0, v.gapmax));
        send_byte(acc ^ v.flip);
        check($sformatf("v%0d_done", id), 32'(load_done), 32'(v.exp_done));
        check($sformatf("v%0d_err", id), 32'(load_err), 32'(!v.exp_done));
        check($sformatf("v%0d_code", id), 32'(err_code), 32'(v.exp_code));
        check($sformatf("v%0d_words", id), 32'(words_loaded), 32'(v.n));
        check($sformatf("v%0d_busy_end", id), 32'(busy), 32'd0);
        check($sformatf("v%0d_ready_end", id), 32'(in_ready), 32'd0);
        check($sformatf("v%0d_nwrites", id), 32'(n_writes - w_start), 32'(v.n));
        check($sformatf("v%0d_q_empty", id), 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_pulse_done", id), 32'(load_done), 32'd0);
        check($sformatf("v%0d_pulse_err", id), 32'(load_err), 32'd0);
        check($sformatf("v%0d_idle_ready", id), 32'(in_ready), 32'd1);
        check($sformatf("v%0d_code_held", id), 32'(err_code), 32'(v.exp_code));
    endtask

    vec_t vecs[7];

    initial begin
        int w0;
        int d0;
        int e0;

        vecs[0] = '{0, 1,   1'b1, 32'h12345678, 0, 8'h00, 1'b1, 2'b00};
        vecs[1] = '{3, 1,   1'b1, 32'h12345678, 1, 8'h00, 1'b1, 2'b00};
        vecs[2] = '{0, 1,   1'b1, 32'h12345678, 0, 8'h01, 1'b0, 2'b10};
        vecs[3] = '{0, 0,   1'b0, 32'h0,        1, 8'h00, 1'b1, 2'b00};
        vecs[4] = '{0, 5,   1'b0, 32'h0,        2, 8'h00, 1'b1, 2'b00};
        vecs[5] = '{0, 256, 1'b0, 32'h0,        3, 8'h00, 1'b1, 2'b00};
        vecs[6] = '{1, 3,   1'b0, 32'h0,        1, 8'h80, 1'b0, 2'b10};

        rst_ldr  = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_waddr", 32'(im_waddr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        rst_ldr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            idle(2);
        end

        // Length error: N = 257 is one past the memory size.
        w0 = n_writes;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        check("len_err", 32'(load_err), 32'd1);
        check("len_code", 32'(err_code), 32'd1);
        check("len_busy", 32'(busy), 32'd0);
        check("len_ready", 32'(in_ready), 32'd0);
        check("len_done", 32'(load_done), 32'd0);
        @(negedge clk);
        check("len_idle_ready", 32'(in_ready), 32'd1);
        send_byte(8'h5A);
        check("len_code_held", 32'(err_code), 32'd1);
        check("len_nwrites", 32'(n_writes - w0), 32'd0);
        idle(2);

        // Timeout: stream stalls mid-word for 16 cycles.
        w0 = n_writes;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (15) @(negedge clk);
        check("tmo_not_yet", 32'(load_err), 32'd0);
        check("tmo_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("tmo_err", 32'(load_err), 32'd1);
        check("tmo_code", 32'(err_code), 32'd3);
        check("tmo_words", 32'(words_loaded), 32'd0);
        check("tmo_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        check("tmo_pulse", 32'(load_err), 32'd0);
        check("tmo_code_held", 32'(err_code), 32'd3);
        check("tmo_nwrites", 32'(n_writes - w0), 32'd0);
        run_vec(7, vecs[0]);
        idle(2);

        // Reset mid-frame: ten words land, then the load is abandoned.
        w0 = n_writes;
        d0 = n_done;
        e0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 10; k++) begin
            logic [31:0] w;
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                if (j == 3) exp_q.push_back('{addr: AW'(4 * k), data: w});
                send_byte(w[31 - 8 * j -: 8]);
            end
        end
        send_byte(8'h11);
        in_byte  = 8'h22;
        in_valid = 1'b1;
        rst_ldr  = 1'b1;
        @(negedge clk);
        rst_ldr  = 1'b0;
        in_valid = 1'b0;
        check("mrst_we", 32'(im_we), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_words", 32'(words_loaded), 32'd0);
        idle(20);
        check("mrst_nwrites", 32'(n_writes - w0), 32'd10);
        check("mrst_no_done", 32'(n_done - d0), 32'd0);
        check("mrst_no_err", 32'(n_err - e0), 32'd0);
        check("mrst_q_empty", 32'(exp_q.size()), 32'd0);

        run_vec(8, vecs[4]);
        idle(2);

        summary();
        $finish;
    end

endmodule
